// File: rtl/controle_temporizador.sv
// Microwave cook-timer controller: M:SS keypad entry, once-per-second BCD countdown,
// start/pause/cancel handling and door interlock. Estado exposes the FSM state directly.
module controle_temporizador #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] Tecla,
    input  logic       TeclaValida,
    input  logic       Start,
    input  logic       Stop,
    input  logic       PortaAberta,
    output logic [3:0] Minutos,
    output logic [3:0] DezenaSeg,
    output logic [3:0] Segundos,
    output logic       Magnetron,
    output logic       Pronto,
    output logic [1:0] Estado
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } estado_t;

    // Handshake: Tecla is sampled only on a cycle where TeclaValida is 1; Start and Stop are
    // one-cycle strobes acted on at the rising edge that sees them; there is no back-pressure.
    estado_t       estado, estado_nxt;
    logic [3:0]    min_nxt, dez_nxt, seg_nxt;
    logic [CW-1:0] tick, tick_nxt;
    logic          porta_q;
    logic          tempo_zero;

    assign tempo_zero = (Minutos == 4'd0) && (DezenaSeg == 4'd0) && (Segundos == 4'd0);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado    <= IDLE;
            Minutos   <= 4'd0;
            DezenaSeg <= 4'd0;
            Segundos  <= 4'd0;
            tick      <= '0;
            porta_q   <= 1'b0;
        end else begin
            estado    <= estado_nxt;
            Minutos   <= min_nxt;
            DezenaSeg <= dez_nxt;
            Segundos  <= seg_nxt;
            tick      <= tick_nxt;
            porta_q   <= PortaAberta;
        end
    end

    always_comb begin
        estado_nxt = estado;
        min_nxt    = Minutos;
        dez_nxt    = DezenaSeg;
        seg_nxt    = Segundos;
        tick_nxt   = tick;
        case (estado)
            IDLE: begin
                if (Stop) begin
                    min_nxt = 4'd0;
                    dez_nxt = 4'd0;
                    seg_nxt = 4'd0;
                end else if (Start && !PortaAberta && !tempo_zero) begin
                    estado_nxt = RUN;
                    tick_nxt   = '0;
                end else if (TeclaValida && (Tecla <= 4'd9) && (Segundos <= 4'd5)) begin
                    // Rejecting Segundos>5 keeps the shifted tens-of-seconds digit within 0-5.
                    min_nxt = DezenaSeg;
                    dez_nxt = Segundos;
                    seg_nxt = Tecla;
                end
            end
            RUN: begin
                if (Stop || PortaAberta) begin
                    estado_nxt = PAUSED;
                end else if (tick == TICK_MAX) begin
                    tick_nxt = '0;
                    if (Segundos != 4'd0) begin
                        seg_nxt = Segundos - 4'd1;
                    end else if (DezenaSeg != 4'd0) begin
                        dez_nxt = DezenaSeg - 4'd1;
                        seg_nxt = 4'd9;
                    end else begin
                        min_nxt = Minutos - 4'd1;
                        dez_nxt = 4'd5;
                        seg_nxt = 4'd9;
                    end
                    if ((min_nxt == 4'd0) && (dez_nxt == 4'd0) && (seg_nxt == 4'd0)) begin
                        estado_nxt = DONE;
                    end
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            PAUSED: begin
                if (Stop) begin
                    estado_nxt = IDLE;
                    min_nxt    = 4'd0;
                    dez_nxt    = 4'd0;
                    seg_nxt    = 4'd0;
                end else if (Start && !PortaAberta) begin
                    estado_nxt = RUN;
                end
            end
            DONE: begin
                min_nxt = 4'd0;
                dez_nxt = 4'd0;
                seg_nxt = 4'd0;
                // Any user action only acknowledges; a key pressed here is not entered.
                if (Stop || Start || TeclaValida || (PortaAberta && !porta_q)) begin
                    estado_nxt = IDLE;
                end
            end
            default: estado_nxt = IDLE;
        endcase
    end

    assign Estado    = estado;
    assign Magnetron = (estado == RUN);
    assign Pronto    = (estado == DONE);

endmodule

// File: tb/tb_controle_temporizador.sv
// Bench for controle_temporizador: directed scenarios plus a randomized run checked against
// a model that tracks the cook time as a plain count of seconds.
module tb_controle_temporizador;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] Tecla;
    logic       TeclaValida;
    logic       Start;
    logic       Stop;
    logic       PortaAberta;
    logic [3:0] Minutos;
    logic [3:0] DezenaSeg;
    logic [3:0] Segundos;
    logic       Magnetron;
    logic       Pronto;
    logic [1:0] Estado;

    logic [15:0] obs;
    assign obs = {Minutos, DezenaSeg, Segundos, Estado, Magnetron, Pronto};

    int checks;
    int failures;

    // model: 0 idle, 1 run, 2 paused, 3 done
    int m_state;
    int m_secs;
    int m_tick;
    bit m_door_prev;

    controle_temporizador #(.TICK_DIV(4)) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .Tecla(Tecla),
        .TeclaValida(TeclaValida),
        .Start(Start),
        .Stop(Stop),
        .PortaAberta(PortaAberta),
        .Minutos(Minutos),
        .DezenaSeg(DezenaSeg),
        .Segundos(Segundos),
        .Magnetron(Magnetron),
        .Pronto(Pronto),
        .Estado(Estado)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic model_reset();
        m_state     = 0;
        m_secs      = 0;
        m_tick      = 0;
        m_door_prev = 1'b0;
    endtask

    task automatic model_step(input bit stp, input bit sta, input bit kv,
                              input logic [3:0] key, input bit door);
        case (m_state)
            0: begin
                if (stp) m_secs = 0;
                else if (sta && !door && m_secs != 0) begin
                    m_state = 1;
                    m_tick  = 0;
                end else if (kv && key <= 9 && (m_secs % 10) <= 5)
                    m_secs = ((m_secs % 60) / 10) * 60 + (m_secs % 10) * 10 + int'(key);
            end
            1: begin
                if (stp || door) m_state = 2;
                else if (m_tick == 3) begin
                    m_tick = 0;
                    m_secs = m_secs - 1;
                    if (m_secs == 0) m_state = 3;
                end else m_tick = m_tick + 1;
            end
            2: begin
                if (stp) begin
                    m_state = 0;
                    m_secs  = 0;
                end else if (sta && !door) m_state = 1;
            end
            default: begin
                m_secs = 0;
                if (stp || sta || kv || (door && !m_door_prev)) m_state = 0;
            end
        endcase
        m_door_prev = door;
    endtask

    task automatic step(input bit stp, input bit sta, input bit kv,
                        input logic [3:0] key, input bit door);
        Stop        = stp;
        Start       = sta;
        TeclaValida = kv;
        Tecla       = key;
        PortaAberta = door;
        @(posedge Clock);
        model_step(stp, sta, kv, key, door);
        #1;
        Stop        = 1'b0;
        Start       = 1'b0;
        TeclaValida = 1'b0;
    endtask

    task automatic press(input logic [3:0] key);
        step(1'b0, 1'b0, 1'b1, key, 1'b0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        Tecla       = 4'd0;
        TeclaValida = 1'b0;
        Start       = 1'b0;
        Stop        = 1'b0;
        PortaAberta = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_no_clock got=%h exp=%h", obs, 16'h0000);
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_clocked got=%h exp=%h", obs, 16'h0000);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_count();
        press(4'd1); press(4'd3); press(4'd0);
        checks++;
        if (obs !== {12'h130, 2'b00, 2'b00}) begin
            failures++;
            $display("FAIL entry_130 got=%h exp=%h", obs, {12'h130, 2'b00, 2'b00});
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== {12'h130, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL start_run got=%h exp=%h", obs, {12'h130, 2'b01, 2'b10});
        end
        wait_cycles(3);
        checks++;
        if (obs !== {12'h130, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL before_tick got=%h exp=%h", obs, {12'h130, 2'b01, 2'b10});
        end
        wait_cycles(1);
        checks++;
        if (obs !== {12'h129, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL first_tick got=%h exp=%h", obs, {12'h129, 2'b01, 2'b10});
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL cancel got=%h exp=%h", obs, 16'h0000);
        end
    endtask

    task automatic test_double_borrow();
        press(4'd1); press(4'd0); press(4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(4);
        checks++;
        if (obs !== {12'h059, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL double_borrow got=%h exp=%h", obs, {12'h059, 2'b01, 2'b10});
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_done();
        press(4'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(3);
        checks++;
        if (obs !== {12'h001, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL done_pre got=%h exp=%h", obs, {12'h001, 2'b01, 2'b10});
        end
        wait_cycles(1);
        checks++;
        if (obs !== {12'h000, 2'b11, 2'b01}) begin
            failures++;
            $display("FAIL done_reached got=%h exp=%h", obs, {12'h000, 2'b11, 2'b01});
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL done_ack got=%h exp=%h", obs, 16'h0000);
        end
    endtask

    task automatic test_pause_door();
        press(4'd1); press(4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(2);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++;
        if (obs !== {12'h010, 2'b10, 2'b00}) begin
            failures++;
            $display("FAIL door_pause got=%h exp=%h", obs, {12'h010, 2'b10, 2'b00});
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        checks++;
        if (obs !== {12'h010, 2'b10, 2'b00}) begin
            failures++;
            $display("FAIL start_door_open got=%h exp=%h", obs, {12'h010, 2'b10, 2'b00});
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(1);
        checks++;
        if (obs !== {12'h010, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL resume_held got=%h exp=%h", obs, {12'h010, 2'b01, 2'b10});
        end
        wait_cycles(1);
        checks++;
        if (obs !== {12'h009, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL resume_tick got=%h exp=%h", obs, {12'h009, 2'b01, 2'b10});
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL paused_stop got=%h exp=%h", obs, 16'h0000);
        end
    endtask

    task automatic test_rejects();
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL start_zero got=%h exp=%h", obs, 16'h0000);
        end
        press(4'd6); press(4'd7);
        checks++;
        if (obs !== {12'h006, 4'b0000}) begin
            failures++;
            $display("FAIL key_seg_gt5 got=%h exp=%h", obs, {12'h006, 4'b0000});
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        press(4'd3); press(4'hA);
        checks++;
        if (obs !== {12'h003, 4'b0000}) begin
            failures++;
            $display("FAIL key_hex got=%h exp=%h", obs, {12'h003, 4'b0000});
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        checks++;
        if (obs !== {12'h003, 4'b0000}) begin
            failures++;
            $display("FAIL start_door got=%h exp=%h", obs, {12'h003, 4'b0000});
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== {12'h003, 2'b10, 2'b00}) begin
            failures++;
            $display("FAIL stop_start_run got=%h exp=%h", obs, {12'h003, 2'b10, 2'b00});
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_done_consume();
        press(4'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(4);
        press(4'd5);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL done_key_consumed got=%h exp=%h", obs, 16'h0000);
        end
        press(4'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(4);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL done_door_rise got=%h exp=%h", obs, 16'h0000);
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        press(4'd2); press(4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(2);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, 16'h0000);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [11:0] exp_t;
        logic [3:0]  key;
        bit          door;
        do_reset();
        door = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) door = ~door;
            key = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), key, door);
            exp_t = {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
            checks++;
            if (obs !== {exp_t, 2'(m_state), (m_state == 1), (m_state == 3)}) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, obs,
                         {exp_t, 2'(m_state), (m_state == 1), (m_state == 3)});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        @(negedge Clock);
        test_count();
        test_double_borrow();
        test_done();
        test_pause_door();
        test_rejects();
        test_done_consume();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
